// File: rtl/pipeline_barrier_param.sv
// Parametrised inter-stage pipeline barrier: NUM_STAGES register slots with per-slot valid,
// ready/valid backpressure, stall, flush and bubble squeezing.
module pipeline_barrier_param #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int NUM_STAGES = 1,
  parameter int CNT_WIDTH  = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  logic [NUM_STAGES-1:0] r_valid;
  logic [DATA_WIDTH-1:0] r_data [NUM_STAGES];
  logic [CTRL_WIDTH-1:0] r_ctrl [NUM_STAGES];
  logic [CNT_WIDTH-1:0]  r_occupancy;

  logic [NUM_STAGES:0]   w_en;
  logic [NUM_STAGES-1:0] w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data [NUM_STAGES];
  logic [CTRL_WIDTH-1:0] w_src_ctrl [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_valid_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;

  // Enable chain runs from the output side back to the input: an empty slot always advances.
  always_comb begin
    w_en = '0;
    w_en[NUM_STAGES] = out_ready & ~stall;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      w_en[k] = ~stall & (~r_valid[k] | w_en[k+1]);
    end
  end

  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    w_src_ctrl[0]  = in_ctrl;
    for (int k = 1; k < NUM_STAGES; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_ctrl[k]  = r_ctrl[k-1];
    end
  end

  always_comb begin
    w_valid_nxt = '0;
    w_cnt_nxt   = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (flush) begin
        w_valid_nxt[k] = 1'b0;
      end else if (w_en[k]) begin
        w_valid_nxt[k] = w_src_valid[k];
      end else begin
        w_valid_nxt[k] = r_valid[k];
      end
      w_cnt_nxt = w_cnt_nxt + CNT_WIDTH'(w_valid_nxt[k]);
    end
  end

  // Flush clears valid and ctrl but leaves data in place; data of an invalid slot is never used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_occupancy <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_data[k] <= '0;
        r_ctrl[k] <= '0;
      end
    end else begin
      r_valid     <= w_valid_nxt;
      r_occupancy <= w_cnt_nxt;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (flush) begin
          r_ctrl[k] <= '0;
        end else if (w_en[k]) begin
          r_data[k] <= w_src_data[k];
          r_ctrl[k] <= w_src_valid[k] ? w_src_ctrl[k] : '0;
        end
      end
    end
  end

  assign in_ready  = w_en[0] & rst_n;
  assign out_valid = r_valid[NUM_STAGES-1];
  assign out_data  = r_data[NUM_STAGES-1];
  assign out_ctrl  = r_ctrl[NUM_STAGES-1];
  assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipeline_barrier_param.sv
// Directed bench for pipeline_barrier_param: vector table on a 3-slot barrier plus
// hand-written sequences for bubble squeezing (N=2), bubble ctrl zeroing (N=1) and async reset.
module tb_pipeline_barrier_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        stall, flush, out_ready;

  logic        o3_in_ready, o3_out_valid;
  logic [15:0] o3_out_data;
  logic [7:0]  o3_out_ctrl;
  logic [1:0]  o3_occ;
  logic        o2_in_ready, o2_out_valid;
  logic [15:0] o2_out_data;
  logic [7:0]  o2_out_ctrl;
  logic [1:0]  o2_occ;
  logic        o1_in_ready, o1_out_valid;
  logic [15:0] o1_out_data;
  logic [7:0]  o1_out_ctrl;
  logic [0:0]  o1_occ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_barrier_param #(.DATA_WIDTH(16), .CTRL_WIDTH(8), .NUM_STAGES(3)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o3_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(o3_out_valid), .out_ready(out_ready), .out_data(o3_out_data),
    .out_ctrl(o3_out_ctrl), .occupancy(o3_occ));

  pipeline_barrier_param #(.DATA_WIDTH(16), .CTRL_WIDTH(8), .NUM_STAGES(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o2_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(o2_out_valid), .out_ready(out_ready), .out_data(o2_out_data),
    .out_ctrl(o2_out_ctrl), .occupancy(o2_occ));

  pipeline_barrier_param #(.DATA_WIDTH(16), .CTRL_WIDTH(8), .NUM_STAGES(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(o1_out_valid), .out_ready(out_ready), .out_data(o1_out_data),
    .out_ctrl(o1_out_ctrl), .occupancy(o1_occ));

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic [7:0]  ic;
    logic        st;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic [7:0]  e_oc;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic iv, logic [15:0] id, logic [7:0] ic, logic st, logic fl,
                              logic ordy, logic e_ir, logic e_ov, logic [15:0] e_od,
                              logic [7:0] e_oc, logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.st = st; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with rst_n released.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    tbl[0]  = mk(1, 16'h00A1, 8'h11, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd1);
    tbl[1]  = mk(1, 16'h00B2, 8'h22, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd2);
    tbl[2]  = mk(1, 16'h00C3, 8'h33, 0, 0, 1,  1, 1, 16'h00A1, 8'h11, 2'd3);
    tbl[3]  = mk(0, 16'h0000, 8'h00, 0, 0, 1,  1, 1, 16'h00B2, 8'h22, 2'd2);
    tbl[4]  = mk(0, 16'h0000, 8'h00, 0, 0, 1,  1, 1, 16'h00C3, 8'h33, 2'd1);
    tbl[5]  = mk(0, 16'h0000, 8'h00, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd0);
    tbl[6]  = mk(1, 16'h00D4, 8'h44, 0, 0, 0,  1, 0, 16'h0000, 8'h00, 2'd1);
    tbl[7]  = mk(1, 16'h00E5, 8'h55, 0, 0, 0,  1, 0, 16'h0000, 8'h00, 2'd2);
    tbl[8]  = mk(1, 16'h00F6, 8'h66, 0, 0, 0,  1, 1, 16'h00D4, 8'h44, 2'd3);
    tbl[9]  = mk(1, 16'h00C7, 8'h77, 0, 0, 0,  0, 1, 16'h00D4, 8'h44, 2'd3);
    tbl[10] = mk(1, 16'h00C7, 8'h77, 0, 0, 1,  1, 1, 16'h00E5, 8'h55, 2'd3);
    tbl[11] = mk(1, 16'h00D8, 8'h88, 1, 0, 1,  0, 1, 16'h00E5, 8'h55, 2'd3);
    tbl[12] = mk(1, 16'h00D8, 8'h88, 1, 1, 1,  0, 0, 16'h0000, 8'h00, 2'd0);
    tbl[13] = mk(0, 16'h1234, 8'hFF, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd0);
    tbl[14] = mk(1, 16'h00E9, 8'h99, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd1);
    tbl[15] = mk(1, 16'h00FA, 8'hAA, 0, 1, 1,  1, 0, 16'h0000, 8'h00, 2'd0);
    tbl[16] = mk(0, 16'h0000, 8'h00, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd0);
    tbl[17] = mk(0, 16'h0000, 8'h00, 0, 0, 1,  1, 0, 16'h0000, 8'h00, 2'd0);

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset out_valid", 32'(o3_out_valid), 32'd0);
    chk("reset out_ctrl", 32'(o3_out_ctrl), 32'd0);
    chk("reset out_data", 32'(o3_out_data), 32'd0);
    chk("reset occupancy", 32'(o3_occ), 32'd0);
    chk("reset in_ready", 32'(o3_in_ready), 32'd0);
    do_reset();

    // N=3 vector table: in_ready checked before the edge, registered outputs after it.
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; in_ctrl = tbl[i].ic;
      stall = tbl[i].st; flush = tbl[i].fl; out_ready = tbl[i].ordy;
      #2;
      chk($sformatf("v%0d in_ready", i), 32'(o3_in_ready), 32'(tbl[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(o3_out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d out_ctrl", i), 32'(o3_out_ctrl), 32'(tbl[i].e_oc));
      chk($sformatf("v%0d occupancy", i), 32'(o3_occ), 32'(tbl[i].e_occ));
      if (tbl[i].e_ov)
        chk($sformatf("v%0d out_data", i), 32'(o3_out_data), 32'(tbl[i].e_od));
    end

    // N=2 bubble squeezing under out_ready=0
    do_reset();
    in_valid = 1'b1; in_data = 16'h0ABC; in_ctrl = 8'h3C; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    chk("n2 first edge out_valid", 32'(o2_out_valid), 32'd0);
    chk("n2 first edge occupancy", 32'(o2_occ), 32'd1);
    @(posedge clk); #1;
    chk("n2 squeeze out_valid", 32'(o2_out_valid), 32'd1);
    chk("n2 squeeze out_data", 32'(o2_out_data), 32'h0ABC);
    chk("n2 squeeze out_ctrl", 32'(o2_out_ctrl), 32'h3C);
    chk("n2 squeeze occupancy", 32'(o2_occ), 32'd1);
    chk("n2 squeeze in_ready", 32'(o2_in_ready), 32'd1);

    // N=1 bubble ctrl zeroing
    do_reset();
    in_valid = 1'b0; in_data = 16'h5555; in_ctrl = 8'hFF; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("n1 bubble out_ctrl", 32'(o1_out_ctrl), 32'h00);
    chk("n1 bubble out_valid", 32'(o1_out_valid), 32'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("n1 valid out_ctrl", 32'(o1_out_ctrl), 32'hFF);
    chk("n1 valid out_data", 32'(o1_out_data), 32'h5555);

    // N=3 async reset mid-stream, then latency after release
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0100 + i); in_ctrl = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    chk("pre-reset out_valid", 32'(o3_out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(o3_out_valid), 32'd0);
    chk("async reset out_data", 32'(o3_out_data), 32'd0);
    chk("async reset out_ctrl", 32'(o3_out_ctrl), 32'd0);
    chk("async reset occupancy", 32'(o3_occ), 32'd0);
    chk("async reset in_ready", 32'(o3_in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h0BEE; in_ctrl = 8'h5A;
    #1;
    chk("post-reset in_ready", 32'(o3_in_ready), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      lat++;
    end while (!o3_out_valid && lat < 10);
    chk("post-reset latency", 32'(lat), 32'd3);
    chk("post-reset out_data", 32'(o3_out_data), 32'h0BEE);
    chk("post-reset out_ctrl", 32'(o3_out_ctrl), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
